// File: rtl/rf_pkg.sv
// Shared widths, requester identifiers and the writeback request record for the register-file writeback path.
package rf_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NREG = 1 << AW;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } wb_req_t;

    function automatic req_id_t other_req(input req_id_t r);
        return (r == REQ_A) ? REQ_B : REQ_A;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write bit vector: set on claim, cleared on writeback, read by two combinational query ports.
// Latency: a set or clear becomes visible on the query ports the cycle after its clock edge; no backpressure.
// Backpressure: none, every set/clear is absorbed in the cycle it is presented.
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    input  logic [AW-1:0] q1_addr,
    input  logic [AW-1:0] q2_addr,
    output logic          q1_busy,
    output logic          q2_busy
);

    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_nxt;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;

    // Clear is applied before set so a same-cycle claim of the written register stays pending.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en && (set_addr != '0)) set_mask[set_addr] = 1'b1;
        if (clr_en)                     clr_mask[clr_addr] = 1'b1;
        pend_nxt    = (pend & ~clr_mask) | set_mask;
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pend <= '0;
        else      pend <= pend_nxt;
    end

    assign q1_busy = pend[q1_addr];
    assign q2_busy = pend[q2_addr];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates ALU (A) and load (B) writebacks onto the single register-file write port; optional RF_BYPASS_EN adds forwarding.
// Latency: an accepted write drives rf_we/rf_addr/rf_wdata for one cycle on the cycle after acceptance, 1 write/cycle.
// Backpressure: combinational ready; when both requesters are valid the loser waits, round-robin after each contest.
module rf_wb_arbiter
    import rf_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [AW-1:0]   a_addr,
    input  logic [XLEN-1:0] a_data,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [AW-1:0]   b_addr,
    input  logic [XLEN-1:0] b_data,
    output logic            rf_we,
    output logic [AW-1:0]   rf_addr,
    output logic [XLEN-1:0] rf_wdata,
    input  logic            claim_valid,
    input  logic [AW-1:0]   claim_addr,
    input  logic [AW-1:0]   chk_addr1,
    input  logic [AW-1:0]   chk_addr2,
    output logic            busy1,
    output logic            busy2
`ifdef RF_BYPASS_EN
    ,
    output logic            byp1_hit,
    output logic            byp2_hit,
    output logic [XLEN-1:0] byp_data
`endif
);

    req_id_t rr_ptr;
    req_id_t rr_ptr_nxt;
    wb_req_t grant_req;
    logic    grant_vld;
    logic    sb_busy1;
    logic    sb_busy2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rr_ptr <= REQ_A;
        else      rr_ptr <= rr_ptr_nxt;
    end

    // The pointer only moves when both requesters competed in the same cycle.
    always_comb begin
        rr_ptr_nxt = rr_ptr;
        if (a_valid && b_valid) rr_ptr_nxt = other_req(rr_ptr);
    end

    always_comb begin
        a_ready   = a_valid && (!b_valid || (rr_ptr == REQ_A));
        b_ready   = b_valid && (!a_valid || (rr_ptr == REQ_B));
        grant_vld = a_ready || b_ready;
        grant_req = b_ready ? wb_req_t'{addr: b_addr, data: b_data}
                            : wb_req_t'{addr: a_addr, data: a_data};
    end

    // x0 writes complete the handshake but never pulse the write enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we    <= 1'b0;
            rf_addr  <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= grant_vld && (grant_req.addr != '0);
            if (grant_vld) begin
                rf_addr  <= grant_req.addr;
                rf_wdata <= grant_req.data;
            end
        end
    end

    rf_scoreboard u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (claim_valid),
        .set_addr (claim_addr),
        .clr_en   (rf_we),
        .clr_addr (rf_addr),
        .q1_addr  (chk_addr1),
        .q2_addr  (chk_addr2),
        .q1_busy  (sb_busy1),
        .q2_busy  (sb_busy2)
    );

`ifdef RF_BYPASS_EN
    // The value being written this cycle is forwarded so the reader need not wait for the clear.
    always_comb begin
        byp1_hit = rf_we && (rf_addr == chk_addr1) && (rf_addr != '0);
        byp2_hit = rf_we && (rf_addr == chk_addr2) && (rf_addr != '0);
        byp_data = rf_wdata;
        busy1    = sb_busy1 && !byp1_hit;
        busy2    = sb_busy2 && !byp2_hit;
    end
`else
    assign busy1 = sb_busy1;
    assign busy2 = sb_busy2;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: expected writebacks are queued at acceptance and matched on rf_* one cycle later.
module tb_rf_wb_arbiter;
    import rf_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            a_valid = 1'b0, b_valid = 1'b0, claim_valid = 1'b0;
    logic [AW-1:0]   a_addr = '0, b_addr = '0, claim_addr = '0, chk_addr1 = '0, chk_addr2 = '0;
    logic [XLEN-1:0] a_data = '0, b_data = '0;
    logic            a_ready, b_ready, rf_we, busy1, busy2;
    logic [AW-1:0]   rf_addr;
    logic [XLEN-1:0] rf_wdata;
`ifdef RF_BYPASS_EN
    logic            byp1_hit, byp2_hit;
    logic [XLEN-1:0] byp_data;
`endif

    int      errors = 0;
    int      checks = 0;
    wb_req_t exp_q[$];
    wb_req_t mon_e;
    req_id_t exp_ptr = REQ_A;

    rf_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
        .claim_valid(claim_valid), .claim_addr(claim_addr),
        .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
        .busy1(busy1), .busy2(busy2)
`ifdef RF_BYPASS_EN
        , .byp1_hit(byp1_hit), .byp2_hit(byp2_hit), .byp_data(byp_data)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    // Writeback monitor: rf_* is sampled 3 time units after each rising edge.
    always @(posedge clk) begin
        #3;
        if (rf_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: rf_we=1 rf_addr=%0d rf_wdata=%h, required no write", rf_addr, rf_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (rf_addr !== mon_e.addr || rf_wdata !== mon_e.data) begin
                    errors++;
                    $display("FAIL wb_data: rf_addr=%0d rf_wdata=%h, required addr=%0d data=%h",
                             rf_addr, rf_wdata, mon_e.addr, mon_e.data);
                end
            end
        end else if (exp_q.size() != 0) begin
            checks++;
            errors++;
            mon_e = exp_q.pop_front();
            $display("FAIL wb_missing: rf_we=%b, required write addr=%0d data=%h", rf_we, mon_e.addr, mon_e.data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        chk_addr1 = 5'd7;
        chk_addr2 = 5'd9;
        #12;
        checks++;
        if (rf_we !== 1'b0 || rf_addr !== '0 || rf_wdata !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rf_we=%b rf_addr=%0d rf_wdata=%h, required 0/0/0", rf_we, rf_addr, rf_wdata);
        end
        checks++;
        if (busy1 !== 1'b0 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: busy1=%b busy2=%b, required 0/0", busy1, busy2);
        end
        @(negedge clk);
        rst = 1'b1;
        exp_ptr = REQ_A;
    endtask

    task automatic test_a_only();
        tick();
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL a_only_ready: a_ready=%b b_ready=%b, required 1/0", a_ready, b_ready);
        end
        exp_q.push_back(wb_req_t'{addr: 5'd5, data: 32'hDEAD_BEEF});
        tick();
        a_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b1 || rf_addr !== 5'd5 || rf_wdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL a_only_wb: rf_we=%b rf_addr=%0d rf_wdata=%h, required 1/5/deadbeef", rf_we, rf_addr, rf_wdata);
        end
        tick();
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL a_only_pulse: rf_we=%b one cycle later, required 0", rf_we);
        end
    endtask

    // Drains per-requester write lists through the arbiter against a round-robin model.
    task automatic test_arbitration(input bit rnd, input int n);
        wb_req_t la[$];
        wb_req_t lb[$];
        bit      a_done = 1'b0, b_done = 1'b0, exp_ar, exp_br;
        int      cyc = 0;
        if (!rnd) begin
            la.push_back(wb_req_t'{addr: 5'd3,  data: 32'hA000_0003});
            la.push_back(wb_req_t'{addr: 5'd6,  data: 32'hA000_0006});
            la.push_back(wb_req_t'{addr: 5'd10, data: 32'hA000_000A});
            lb.push_back(wb_req_t'{addr: 5'd4,  data: 32'hB000_0004});
            lb.push_back(wb_req_t'{addr: 5'd11, data: 32'hB000_000B});
        end else begin
            for (int i = 0; i < n; i++) begin
                la.push_back(wb_req_t'{addr: AW'($urandom_range(0, NREG-1)), data: $urandom});
                lb.push_back(wb_req_t'{addr: AW'($urandom_range(0, NREG-1)), data: $urandom});
            end
        end
        while ((la.size() != 0 || lb.size() != 0) && cyc < 500) begin
            tick();
            cyc++;
            if (a_done) a_valid = 1'b0;
            if (b_done) b_valid = 1'b0;
            if (!a_valid && la.size() != 0 && (!rnd || $urandom_range(0, 3) != 0)) begin
                a_valid = 1'b1; a_addr = la[0].addr; a_data = la[0].data;
            end
            if (!b_valid && lb.size() != 0 && (!rnd || $urandom_range(0, 3) != 0)) begin
                b_valid = 1'b1; b_addr = lb[0].addr; b_data = lb[0].data;
            end
            @(negedge clk);
            exp_ar = a_valid && (!b_valid || exp_ptr == REQ_A);
            exp_br = b_valid && (!a_valid || exp_ptr == REQ_B);
            checks++;
            if (a_ready !== exp_ar || b_ready !== exp_br) begin
                errors++;
                $display("FAIL arb_grant: cycle=%0d a_ready=%b b_ready=%b, required %b/%b", cyc, a_ready, b_ready, exp_ar, exp_br);
            end
            if (exp_ar) begin
                if (a_addr != '0) exp_q.push_back(wb_req_t'{addr: a_addr, data: a_data});
                void'(la.pop_front());
            end
            if (exp_br) begin
                if (b_addr != '0) exp_q.push_back(wb_req_t'{addr: b_addr, data: b_data});
                void'(lb.pop_front());
            end
            a_done = exp_ar;
            b_done = exp_br;
            if (a_valid && b_valid) exp_ptr = other_req(exp_ptr);
        end
        tick();
        a_valid = 1'b0;
        b_valid = 1'b0;
        checks++;
        if (la.size() != 0 || lb.size() != 0) begin
            errors++;
            $display("FAIL arb_timeout: %0d/%0d writes left after %0d cycles, required 0/0", la.size(), lb.size(), cyc);
        end
        tick();
    endtask

    task automatic test_x0();
        tick();
        b_valid = 1'b1; b_addr = '0; b_data = 32'hFFFF_FFFF;
        claim_valid = 1'b1; claim_addr = '0; chk_addr1 = '0;
        @(negedge clk);
        checks++;
        if (b_ready !== 1'b1) begin
            errors++;
            $display("FAIL x0_ready: b_ready=%b, required 1", b_ready);
        end
        tick();
        b_valid = 1'b0; claim_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL x0_write: rf_we=%b busy1=%b, required 0/0", rf_we, busy1);
        end
    endtask

    task automatic test_claim_write();
        tick();
        claim_valid = 1'b1; claim_addr = 5'd7; chk_addr1 = 5'd7; chk_addr2 = 5'd7;
        @(negedge clk);
        checks++;
        if (busy1 !== 1'b0) begin
            errors++;
            $display("FAIL claim_early: busy1=%b in claim cycle, required 0", busy1);
        end
        tick();
        claim_valid = 1'b0;
        a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h0000_0777;
        @(negedge clk);
        checks++;
        if (busy1 !== 1'b1 || busy2 !== 1'b1 || a_ready !== 1'b1) begin
            errors++;
            $display("FAIL claim_pending: busy1=%b busy2=%b a_ready=%b, required 1/1/1", busy1, busy2, a_ready);
        end
        exp_q.push_back(wb_req_t'{addr: 5'd7, data: 32'h0000_0777});
        tick();
        a_valid = 1'b0;
        @(negedge clk);
        checks++;
`ifdef RF_BYPASS_EN
        if (rf_we !== 1'b1 || busy1 !== 1'b0 || byp1_hit !== 1'b1 || byp2_hit !== 1'b1 || byp_data !== 32'h0000_0777) begin
            errors++;
            $display("FAIL claim_wb_cycle: rf_we=%b busy1=%b hit1=%b hit2=%b byp=%h, required 1/0/1/1/777",
                     rf_we, busy1, byp1_hit, byp2_hit, byp_data);
        end
`else
        if (rf_we !== 1'b1 || busy1 !== 1'b1 || busy2 !== 1'b1) begin
            errors++;
            $display("FAIL claim_wb_cycle: rf_we=%b busy1=%b busy2=%b, required 1/1/1", rf_we, busy1, busy2);
        end
`endif
        tick();
        @(negedge clk);
        checks++;
        if (busy1 !== 1'b0 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL claim_cleared: busy1=%b busy2=%b, required 0/0", busy1, busy2);
        end
    endtask

    task automatic test_claim_clear_same();
        tick();
        b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h0000_0999;
        @(negedge clk);
        checks++;
        if (b_ready !== 1'b1) begin
            errors++;
            $display("FAIL same_ready: b_ready=%b, required 1", b_ready);
        end
        exp_q.push_back(wb_req_t'{addr: 5'd9, data: 32'h0000_0999});
        tick();
        b_valid = 1'b0;
        claim_valid = 1'b1; claim_addr = 5'd9; chk_addr1 = 5'd9; chk_addr2 = 5'd9;
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b1 || rf_addr !== 5'd9) begin
            errors++;
            $display("FAIL same_wb: rf_we=%b rf_addr=%0d, required 1/9", rf_we, rf_addr);
        end
        tick();
        claim_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (busy1 !== 1'b1 || busy2 !== 1'b1) begin
                errors++;
                $display("FAIL same_set_wins: cycle=%0d busy1=%b busy2=%b, required 1/1", i, busy1, busy2);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        bit exp_ar;
        int rounds = 0;
        tick();
        a_valid = 1'b1; a_addr = 5'd12; a_data = 32'hA000_000C;
        b_valid = 1'b1; b_addr = 5'd13; b_data = 32'hB000_000D;
        // Contest until the pointer rests on B so a restored A priority is observable.
        do begin
            if (rounds != 0) begin
                tick();
                if (exp_ar) begin a_addr = 5'd14; a_data = 32'hA000_000E; end
                else        begin b_addr = 5'd15; b_data = 32'hB000_000F; end
            end
            @(negedge clk);
            exp_ar = (exp_ptr == REQ_A);
            checks++;
            if (a_ready !== exp_ar || b_ready !== !exp_ar) begin
                errors++;
                $display("FAIL mid_grant: a_ready=%b b_ready=%b, required %b/%b", a_ready, b_ready, exp_ar, !exp_ar);
            end
            if (exp_ar) exp_q.push_back(wb_req_t'{addr: a_addr, data: a_data});
            else        exp_q.push_back(wb_req_t'{addr: b_addr, data: b_data});
            exp_ptr = other_req(exp_ptr);
            rounds++;
        end while (exp_ptr != REQ_B && rounds < 3);
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        #3;
        checks++;
        if (rf_we !== 1'b1 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL mid_before: rf_we=%b busy1=%b, required 1/1", rf_we, busy1);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (rf_we !== 1'b0 || rf_addr !== '0 || busy1 !== 1'b0 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: rf_we=%b rf_addr=%0d busy1=%b busy2=%b, required 0/0/0/0", rf_we, rf_addr, busy1, busy2);
        end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        exp_ptr = REQ_A;
        tick();
        a_valid = 1'b1; a_addr = 5'd20; a_data = 32'hA000_0014;
        b_valid = 1'b1; b_addr = 5'd21; b_data = 32'hB000_0015;
        @(negedge clk);
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_priority: a_ready=%b b_ready=%b, required 1/0", a_ready, b_ready);
        end
        exp_q.push_back(wb_req_t'{addr: 5'd20, data: 32'hA000_0014});
        exp_ptr = other_req(exp_ptr);
        tick();
        a_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (b_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_b_follow: b_ready=%b, required 1", b_ready);
        end
        exp_q.push_back(wb_req_t'{addr: 5'd21, data: 32'hB000_0015});
        tick();
        b_valid = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_a_only();
        test_arbitration(1'b0, 0);
        test_arbitration(1'b1, 40);
        test_x0();
        test_claim_write();
        test_claim_clear_same();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
